// File: rtl/reg_file_pkg.sv
// Shared constants for the multi-port register file and its busy scoreboard.
package reg_file_pkg;

  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_NUM_RD = 2;
  localparam int unsigned DEPTH      = 2 ** DEF_ADDR_W;
  localparam int unsigned ZERO_ADDR  = 0;

endpackage : reg_file_pkg

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits: decode sets, writeback clears, and a same-edge set wins.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  logic [(2**ADDR_W)-1:0] r_busy;

  // The set is applied after the clear so the new producer owns the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      if (clr_en) r_busy[clr_addr] <= 1'b0;
      if (set_en) r_busy[set_addr] <= 1'b1;
    end
  end

  assign busy_vec = r_busy;

endmodule : reg_file_scoreboard

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with registered read latches, write bypass,
// optional hardwired zero register and a busy scoreboard.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hold,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       set_busy,
  input  logic [ADDR_W-1:0]          sb_addr,
  output logic [(2**ADDR_W)-1:0]     busy_vec
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [NREG];
  logic [NREG-1:0]   w_busy;
  logic              w_wr_ok;
  logic              w_set_ok;

  // Address 0 swallows writes and allocations when it is hardwired to zero.
  assign w_wr_ok  = wr_en    && !(ZERO_REG && (wr_addr == ADDR_W'(ZERO_ADDR)));
  assign w_set_ok = set_busy && !(ZERO_REG && (sb_addr == ADDR_W'(ZERO_ADDR)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NREG); r++) r_mem[r] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  reg_file_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (w_set_ok),
    .set_addr (sb_addr),
    .clr_en   (w_wr_ok),
    .clr_addr (wr_addr),
    .busy_vec (w_busy)
  );

  assign busy_vec = w_busy;

  for (genvar gi = 0; gi < int'(NUM_RD); gi++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_zero;
    logic              w_hit;
    logic [DATA_W-1:0] w_nxt_data;
    logic              w_nxt_busy;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_busy;

    assign w_ra   = rd_addr[gi*ADDR_W +: ADDR_W];
    assign w_zero = ZERO_REG && (w_ra == ADDR_W'(ZERO_ADDR));
    assign w_hit  = BYPASS && w_wr_ok && (wr_addr == w_ra);

    // A forwarded write is the freshest value and has already retired its producer.
    always_comb begin
      w_nxt_data = r_mem[w_ra];
      w_nxt_busy = w_busy[w_ra];
      if (w_zero) begin
        w_nxt_data = '0;
        w_nxt_busy = 1'b0;
      end else if (w_hit) begin
        w_nxt_data = wr_data;
        w_nxt_busy = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data  <= '0;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else if (!hold) begin
        r_valid <= rd_en[gi];
        if (rd_en[gi]) begin
          r_data <= w_nxt_data;
          r_busy <= w_nxt_busy;
        end
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W] = r_data;
    assign rd_valid[gi]                 = r_valid;
    assign rd_busy[gi]                  = r_busy;
  end : g_rd

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: reset sequence by hand, then a vector table.
module tb_reg_file_mp;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NV = 17;

  logic              clk;
  logic              rst_n;
  logic              hold;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data, rd_data_nb;
  logic [NR-1:0]     rd_valid, rd_valid_nb;
  logic [NR-1:0]     rd_busy, rd_busy_nb;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              set_busy;
  logic [AW-1:0]     sb_addr;
  logic [31:0]       busy_vec, busy_vec_nb;

  int checks   = 0;
  int failures = 0;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .set_busy(set_busy), .sb_addr(sb_addr), .busy_vec(busy_vec)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .hold(hold), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_nb), .rd_valid(rd_valid_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .set_busy(set_busy), .sb_addr(sb_addr), .busy_vec(busy_vec_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          sb;
    logic [AW-1:0] sa;
    logic          hd;
    logic [1:0]    re;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [1:0]    ev;
    logic [1:0]    eb;
    logic [DW-1:0] ed0;
    logic [DW-1:0] ed1;
    logic [DW-1:0] ed1n;
    logic [31:0]   ebv;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic sb, input logic [AW-1:0] sa, input logic hd,
                              input logic [1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                              input logic [1:0] ev, input logic [1:0] eb,
                              input logic [DW-1:0] ed0, input logic [DW-1:0] ed1,
                              input logic [DW-1:0] ed1n, input logic [31:0] ebv);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.sb = sb; v.sa = sa; v.hd = hd;
    v.re = re; v.ra0 = ra0; v.ra1 = ra1;
    v.ev = ev; v.eb = eb; v.ed0 = ed0; v.ed1 = ed1; v.ed1n = ed1n; v.ebv = ebv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic sb, input logic [AW-1:0] sa, input logic hd,
                       input logic [1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    wr_en = we; wr_addr = wa; wr_data = wd;
    set_busy = sb; sb_addr = sa; hold = hd;
    rd_en = re; rd_addr = {ra1, ra0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [DW-1:0] M2 = 64'hFFFF_FFFF_FFFF_FFFE;

  initial begin
    // we  wa   wd      sb sa  hd re    ra0 ra1   ev     eb     ed0       ed1      ed1n     ebv
    vecs[0]  = mk(1, 5,  64'h1234, 0, 0,  0, 2'b00, 0,  0,  2'b00, 2'b00, 64'h0,    64'h0,   64'h0,   32'h0);
    vecs[1]  = mk(0, 0,  64'h0,    0, 0,  0, 2'b01, 5,  0,  2'b01, 2'b00, 64'h1234, 64'h0,   64'h0,   32'h0);
    vecs[2]  = mk(1, 9,  M2,       0, 0,  0, 2'b10, 0,  9,  2'b10, 2'b00, 64'h1234, M2,      64'h0,   32'h0);
    vecs[3]  = mk(0, 0,  64'h0,    0, 0,  0, 2'b11, 9,  9,  2'b11, 2'b00, M2,       M2,      M2,      32'h0);
    vecs[4]  = mk(1, 0,  64'hAA,   1, 0,  0, 2'b00, 0,  0,  2'b00, 2'b00, M2,       M2,      M2,      32'h0);
    vecs[5]  = mk(0, 0,  64'h0,    0, 0,  0, 2'b11, 0,  0,  2'b11, 2'b00, 64'h0,    64'h0,   64'h0,   32'h0);
    vecs[6]  = mk(0, 0,  64'h0,    1, 12, 0, 2'b00, 0,  0,  2'b00, 2'b00, 64'h0,    64'h0,   64'h0,   32'h1000);
    vecs[7]  = mk(0, 0,  64'h0,    0, 0,  0, 2'b01, 12, 0,  2'b01, 2'b01, 64'h0,    64'h0,   64'h0,   32'h1000);
    vecs[8]  = mk(1, 12, 64'h55,   1, 12, 0, 2'b00, 0,  0,  2'b00, 2'b01, 64'h0,    64'h0,   64'h0,   32'h1000);
    vecs[9]  = mk(0, 0,  64'h0,    0, 0,  0, 2'b11, 12, 12, 2'b11, 2'b11, 64'h55,   64'h55,  64'h55,  32'h1000);
    vecs[10] = mk(1, 12, 64'h66,   1, 3,  0, 2'b01, 12, 0,  2'b01, 2'b10, 64'h66,   64'h55,  64'h55,  32'h8);
    vecs[11] = mk(1, 5,  64'h77,   0, 0,  1, 2'b11, 5,  3,  2'b01, 2'b10, 64'h66,   64'h55,  64'h55,  32'h8);
    vecs[12] = mk(1, 3,  64'h88,   0, 0,  1, 2'b00, 0,  0,  2'b01, 2'b10, 64'h66,   64'h55,  64'h55,  32'h0);
    vecs[13] = mk(0, 0,  64'h0,    1, 5,  1, 2'b10, 0,  5,  2'b01, 2'b10, 64'h66,   64'h55,  64'h55,  32'h20);
    vecs[14] = mk(0, 0,  64'h0,    0, 0,  1, 2'b01, 12, 0,  2'b01, 2'b10, 64'h66,   64'h55,  64'h55,  32'h20);
    vecs[15] = mk(0, 0,  64'h0,    0, 0,  0, 2'b11, 5,  3,  2'b11, 2'b01, 64'h77,   64'h88,  64'h88,  32'h20);
    vecs[16] = mk(1, 5,  64'h1,    0, 0,  0, 2'b00, 0,  0,  2'b00, 2'b01, 64'h77,   64'h88,  64'h88,  32'h0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_rd_data", rd_data[DW-1:0], 64'h0);
    chk("reset_rd_valid", 64'(rd_valid), 64'h0);
    chk("reset_busy_vec", 64'(busy_vec), 64'h0);

    // Populate state, then pull reset asynchronously mid-cycle.
    drive(1, 7, 64'hDEAD_BEEF, 1, 4, 0, 2'b00, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 2'b01, 7, 0);
    tick();
    chk("prereset_rd_data", rd_data[DW-1:0], 64'hDEAD_BEEF);
    chk("prereset_busy_vec", 64'(busy_vec), 64'h10);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_rd_data", rd_data[DW-1:0], 64'h0);
    chk("async_rst_rd_valid", 64'(rd_valid), 64'h0);
    chk("async_rst_busy_vec", 64'(busy_vec), 64'h0);
    drive(1, 7, 64'hDEAD_BEEF, 0, 0, 0, 2'b11, 7, 7);
    repeat (3) @(posedge clk);
    #1;
    chk("in_rst_rd_data", rd_data[DW-1:0], 64'h0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 2'b01, 7, 0);
    tick();
    chk("post_rst_rd_data", rd_data[DW-1:0], 64'h0);
    chk("post_rst_rd_valid", 64'(rd_valid), 64'h1);
    chk("post_rst_rd_busy", 64'(rd_busy), 64'h0);

    for (int i = 0; i < int'(NV); i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].sb, vecs[i].sa, vecs[i].hd,
            vecs[i].re, vecs[i].ra0, vecs[i].ra1);
      tick();
      chk($sformatf("v%0d_rd_valid", i), 64'(rd_valid), 64'(vecs[i].ev));
      chk($sformatf("v%0d_rd_busy", i), 64'(rd_busy), 64'(vecs[i].eb));
      chk($sformatf("v%0d_rd_data0", i), rd_data[DW-1:0], vecs[i].ed0);
      chk($sformatf("v%0d_rd_data1", i), rd_data[2*DW-1:DW], vecs[i].ed1);
      chk($sformatf("v%0d_nobyp_rd_data1", i), rd_data_nb[2*DW-1:DW], vecs[i].ed1n);
      chk($sformatf("v%0d_busy_vec", i), 64'(busy_vec), 64'(vecs[i].ebv));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_file_mp
